// File: rtl/ascon_pack.sv
// Shared types, round-count constants and helpers for the ASCON permutation.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;
  typedef logic [3:0]       type_idx;
  typedef enum logic { ST_IDLE, ST_RUN } type_fsm;

  localparam int      ROUNDS_A    = 12;
  localparam int      ROUNDS_B    = 8;
  localparam type_idx IDX_START_A = 4'd0;
  localparam type_idx IDX_START_B = 4'd4;
  localparam type_idx IDX_LAST    = 4'd11;

  // Round constant: high nibble counts down from F while the low nibble counts up.
  function automatic logic [7:0] round_const(input type_idx idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_layers.sv
// The three combinational round layers: constant addition, substitution, linear diffusion.
module ascon_pc
  import ascon_pack::*;
(
  input  type_state state_i,
  input  type_idx   idx_i,
  output type_state state_o
);
  logic [7:0] rc_w;

  assign rc_w = round_const(idx_i);

  always_comb begin
    state_o          = state_i;
    state_o[2][7:0]  = state_i[2][7:0] ^ rc_w;
  end
endmodule

module ascon_ps
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  assign a0 = state_i[0] ^ state_i[4];
  assign a1 = state_i[1];
  assign a2 = state_i[2] ^ state_i[1];
  assign a3 = state_i[3];
  assign a4 = state_i[4] ^ state_i[3];

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign state_o[0] = b0 ^ b4;
  assign state_o[1] = b1 ^ b0;
  assign state_o[2] = ~b2;
  assign state_o[3] = b3 ^ b2;
  assign state_o[4] = b4;
endmodule

module ascon_pl
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  assign state_o[0] = state_i[0] ^ rotr(state_i[0], 19) ^ rotr(state_i[0], 28);
  assign state_o[1] = state_i[1] ^ rotr(state_i[1], 61) ^ rotr(state_i[1], 39);
  assign state_o[2] = state_i[2] ^ rotr(state_i[2], 1)  ^ rotr(state_i[2], 6);
  assign state_o[3] = state_i[3] ^ rotr(state_i[3], 10) ^ rotr(state_i[3], 17);
  assign state_o[4] = state_i[4] ^ rotr(state_i[4], 7)  ^ rotr(state_i[4], 41);
endmodule

// File: rtl/ascon_round_ctrl.sv
// IDLE/RUN sequencer: round index, busy/done flags and the state-load enable.
module ascon_round_ctrl
  import ascon_pack::*;
(
  input  logic    clock_i,
  input  logic    reset_i,
  input  logic    start_i,
  input  logic    rounds_sel_i,
  output logic    load_o,
  output type_idx idx_o,
  output logic    busy_o,
  output logic    done_o,
  output type_fsm fsm_o
);
  type_fsm fsm_q;
  type_idx idx_q;
  logic    busy_q;
  logic    done_q;

  // start_i is only honoured in IDLE, which includes the cycle where done_o is high.
  assign load_o = (fsm_q == ST_IDLE) && start_i;
  assign idx_o  = idx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign fsm_o  = fsm_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q  <= ST_IDLE;
      idx_q  <= IDX_START_A;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (start_i) begin
            idx_q  <= rounds_sel_i ? IDX_START_B : IDX_START_A;
            busy_q <= 1'b1;
            fsm_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The index parks at the last value rather than wrapping.
          if (idx_q == IDX_LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation: one Pc->Ps->Pl round per clock over a 320-bit state register.
module ascon_permutation
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      rounds_sel_i,
  input  type_state state_i,
  output logic      busy_o,
  output logic      done_o,
  output type_state state_o
);
  type_state state_q, state_d;
  type_state pc_w, ps_w, pl_w;
  type_idx   idx_w;
  type_fsm   fsm_w;
  logic      load_w;

  ascon_round_ctrl u_ctrl (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rounds_sel_i (rounds_sel_i),
    .load_o       (load_w),
    .idx_o        (idx_w),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fsm_o        (fsm_w)
  );

  ascon_pc u_pc (.state_i(state_q), .idx_i(idx_w), .state_o(pc_w));
  ascon_ps u_ps (.state_i(pc_w),    .state_o(ps_w));
  ascon_pl u_pl (.state_i(ps_w),    .state_o(pl_w));

  always_comb begin
    state_d = state_q;
    if (load_w)
      state_d = state_i;
    else if (fsm_w == ST_RUN)
      state_d = pl_w;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i)
      state_q <= '0;
    else
      state_q <= state_d;
  end

  assign state_o = state_q;
endmodule
